// File: rtl/dma_io_peripheral.sv
// ---------------------------------------------------------------------------
// dma_io_peripheral
// Device end of a DMA channel handshake (DREQ/DACK/IOR_N/IOW_N/EOP_N).
// A single FIFO is shared by both transfer directions:
//   XFER_DIR=0 : local side fills via src_*, DMA drains via IOR_N cycles.
//   XFER_DIR=1 : DMA fills via IOW_N cycles, local side drains via snk_*.
// Ports:
//   CLK, RESET (async, active high)
//   XFER_DIR        transfer direction, changed only while idle
//   DREQ / DACK     request / acknowledge
//   IOR_N, IOW_N    I/O strobes (active low), EOP_N terminal count (active low)
//   DB_IN / DB_OUT / DB_OE   data bus in, out and output enable
//   src_valid/src_data/src_ready   local push port
//   snk_valid/snk_data/snk_ready   local pop port
//   tc_pulse        one-cycle pulse on terminal count
//   proto_err       sticky protocol error flag
// Build option:
//   DMA_DEMAND_MODE_EN defined   : demand mode, DREQ follows FIFO state across
//                                  strobes within one DACK window.
//   DMA_DEMAND_MODE_EN undefined : single mode, DREQ drops after first strobe.
// ---------------------------------------------------------------------------
module dma_io_peripheral #(
    parameter int DEPTH      = 8,
    parameter int DW         = 8,
    parameter int REQ_THRESH = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          XFER_DIR,
    output logic          DREQ,
    input  logic          DACK,
    input  logic          IOR_N,
    input  logic          IOW_N,
    input  logic          EOP_N,
    input  logic [DW-1:0] DB_IN,
    output logic [DW-1:0] DB_OUT,
    output logic          DB_OE,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic          snk_valid,
    output logic [DW-1:0] snk_data,
    input  logic          snk_ready,
    output logic          tc_pulse,
    output logic          proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(REQ_THRESH);

`ifdef DMA_DEMAND_MODE_EN
    localparam logic DEMAND_MODE = 1'b1;
`else
    localparam logic DEMAND_MODE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_STRB = 2'd3
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            eop_seen_r;

    logic            empty_s;
    logic            full_s;
    logic            ior_low_s;
    logic            iow_low_s;
    logic            both_low_s;
    logic            dir_low_s;
    logic            wrong_low_s;
    logic            active_s;
    logic            strb_done_s;
    logic            eop_hit_s;
    logic            push_s;
    logic            pop_s;
    logic [DW-1:0]   push_data_s;
    logic [CW-1:0]   count_next_s;
    logic            ok_s;
    logic            ok_next_s;
    logic            err_s;

    assign empty_s   = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == DEPTH_C);
    // The local ports only handshake in the direction they serve.
    assign src_ready = ~full_s & ~XFER_DIR;
    assign snk_valid = ~empty_s & XFER_DIR;
    assign snk_data  = mem_r[rd_ptr_r];

    // Strobe decode, FIFO control and request qualification.
    always_comb begin
        ior_low_s    = ~IOR_N;
        iow_low_s    = ~IOW_N;
        both_low_s   = ior_low_s & iow_low_s;
        dir_low_s    = (XFER_DIR ? iow_low_s : ior_low_s) & ~both_low_s;
        wrong_low_s  = (XFER_DIR ? ior_low_s : iow_low_s) & ~both_low_s;
        active_s     = (state_r == ST_XFER) || (state_r == ST_STRB);
        // Completion is the strobe returning high while still in STRB.
        strb_done_s  = (state_r == ST_STRB) && DACK && (XFER_DIR ? IOW_N : IOR_N);
        eop_hit_s    = ~EOP_N && DACK && ~eop_seen_r && (state_r != ST_IDLE);
        push_s       = 1'b0;
        pop_s        = 1'b0;
        push_data_s  = src_data;
        if (XFER_DIR) begin
            push_s      = strb_done_s & ~full_s;
            pop_s       = snk_valid & snk_ready;
            push_data_s = DB_IN;
        end else begin
            push_s      = src_valid & src_ready;
            pop_s       = strb_done_s & ~empty_s;
            push_data_s = src_data;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        if (XFER_DIR) begin
            ok_s      = (DEPTH_C - count_r) >= THRESH_C;
            ok_next_s = (DEPTH_C - count_next_s) >= THRESH_C;
        end else begin
            ok_s      = count_r >= THRESH_C;
            ok_next_s = count_next_s >= THRESH_C;
        end
        err_s = both_low_s
              | ((ior_low_s | iow_low_s) & ~DACK)
              | (DACK & active_s & wrong_low_s)
              | (strb_done_s & XFER_DIR & full_s)
              | ((state_r == ST_XFER) & DACK & ~XFER_DIR & dir_low_s & empty_s);
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Handshake FSM with registered bus outputs and status flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            DREQ       <= 1'b0;
            DB_OUT     <= {DW{1'b0}};
            DB_OE      <= 1'b0;
            tc_pulse   <= 1'b0;
            proto_err  <= 1'b0;
            eop_seen_r <= 1'b0;
        end else begin
            tc_pulse <= eop_hit_s;
            if (err_s) begin
                proto_err <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    DREQ       <= 1'b0;
                    DB_OE      <= 1'b0;
                    eop_seen_r <= 1'b0;
                    if (ok_s) begin
                        state_r <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    DREQ <= 1'b1;
                    if (DACK) begin
                        state_r <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!DACK) begin
                        state_r <= ST_IDLE;
                        DREQ    <= 1'b0;
                    end else if (dir_low_s) begin
                        state_r <= ST_STRB;
                        if (!XFER_DIR) begin
                            DB_OE  <= 1'b1;
                            // Reading an empty FIFO drives zero instead of stale data.
                            DB_OUT <= empty_s ? {DW{1'b0}} : mem_r[rd_ptr_r];
                        end
                    end
                end
                ST_STRB: begin
                    if (!DACK) begin
                        state_r <= ST_IDLE;
                        DREQ    <= 1'b0;
                        DB_OE   <= 1'b0;
                        DB_OUT  <= {DW{1'b0}};
                    end else if (strb_done_s) begin
                        state_r <= ST_XFER;
                        DB_OE   <= 1'b0;
                        DB_OUT  <= {DW{1'b0}};
                        DREQ    <= DEMAND_MODE & ok_next_s & ~eop_seen_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            // Terminal count withdraws the request for the rest of this DACK window.
            if (eop_hit_s) begin
                eop_seen_r <= 1'b1;
                DREQ       <= 1'b0;
            end
        end
    end

endmodule
